// File: rtl/serial_queue_pkg.sv
// Shared types, defaults and helpers for the serial deserializer FIFO.
package serial_queue_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_DEPTH = 8;

   // Which end of the word the first serial bit lands in.
   typedef enum logic {
      LSB_FIRST   = 1'b0,
      MSB_FIRST_E = 1'b1
   } bit_order_e;

   // Pointer width including the wrap bit used to tell full from empty.
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/serial_deser_fifo_if.sv
// Serial input / FIFO status bundle for serial_deser_fifo.
// SERIAL_PARITY_EN adds the parity_err_out line.
interface serial_deser_fifo_if
   import serial_queue_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH
);
   localparam int CW = ptr_width(DEPTH);

   logic             data_in;
   logic             write_in;
   logic             dequeue_in;
   logic             status_out;
   logic [WIDTH-1:0] data_out;
   logic [CW-1:0]    count_out;
   logic             empty_out;
   logic             overflow_out;

`ifdef SERIAL_PARITY_EN
   logic             parity_err_out;

   modport master (
      output data_in, write_in, dequeue_in,
      input  status_out, data_out, count_out, empty_out, overflow_out, parity_err_out
   );

   modport slave (
      input  data_in, write_in, dequeue_in,
      output status_out, data_out, count_out, empty_out, overflow_out, parity_err_out
   );
`else
   modport master (
      output data_in, write_in, dequeue_in,
      input  status_out, data_out, count_out, empty_out, overflow_out
   );

   modport slave (
      input  data_in, write_in, dequeue_in,
      output status_out, data_out, count_out, empty_out, overflow_out
   );
`endif

endinterface

// File: rtl/rise_detect.sv
// Registers a level strobe once, keeps the previous sample and flags
// the single cycle where the registered level first goes high.
module rise_detect (
   input  logic clk,
   input  logic rst,
   input  logic strobe,
   output logic rise
);
   logic q_reg;
   logic prev_reg;

   // Two-stage sample of the strobe: current and previous registered level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_reg    <= 1'b0;
         prev_reg <= 1'b0;
      end else begin
         q_reg    <= strobe;
         prev_reg <= q_reg;
      end
   end

   assign rise = q_reg & ~prev_reg;

endmodule

// File: rtl/serial_deser_fifo.sv
// Bit-serial deserializer feeding a first-word-fall-through FIFO.
// Optional feature macro: SERIAL_PARITY_EN (trailing even-parity bit per word,
// bad words dropped with a one-cycle parity_err_out pulse).
module serial_deser_fifo
   import serial_queue_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int DEPTH     = DEFAULT_DEPTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input logic                clock_1MHz,
   input logic                rst,
   serial_deser_fifo_if.slave bus
);
   localparam int PW = ptr_width(DEPTH);
   localparam int AW = PW - 1;
`ifdef SERIAL_PARITY_EN
   localparam int FRAME_BITS = WIDTH + 1;
`else
   localparam int FRAME_BITS = WIDTH;
`endif
   localparam int              BW       = $clog2(FRAME_BITS);
   localparam logic [BW-1:0]   LAST_BIT = BW'(FRAME_BITS - 1);
   localparam bit_order_e      ORDER    = bit_order_e'(MSB_FIRST);

   logic [1:0]       strobe;
   logic [1:0]       rise;
   logic             w_rise;
   logic             q_rise;
   logic             d_q_reg;

   logic [BW-1:0]    bit_cnt_reg;
   logic [WIDTH-1:0] shift_reg;
   logic [WIDTH-1:0] shift_next;
   logic [WIDTH-1:0] push_word;
   logic             data_bit;
   logic             frame_done;
   logic             push;

   logic [PW-1:0]    wr_ptr_reg;
   logic [PW-1:0]    rd_ptr_reg;
   logic [PW-1:0]    count;
   logic             full;
   logic             empty;
   logic             pop;
   logic             wr_en;
   logic             overflow_reg;
   logic [WIDTH-1:0] mem [DEPTH];

   // Edge detection for both strobes: index 0 = write_in, index 1 = dequeue_in.
   assign strobe = {bus.dequeue_in, bus.write_in};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_edge
         rise_detect u_rise (
            .clk    (clock_1MHz),
            .rst    (rst),
            .strobe (strobe[gi]),
            .rise   (rise[gi])
         );
      end
   endgenerate

   assign w_rise = rise[0];
   assign q_rise = rise[1];

   // Data bit is registered once so it lines up with the registered write strobe.
   always_ff @(posedge clock_1MHz or posedge rst) begin
      if (rst) begin
         d_q_reg <= 1'b0;
      end else begin
         d_q_reg <= bus.data_in;
      end
   end

   // Shift direction is fixed at elaboration by the bit order.
   generate
      if (ORDER == MSB_FIRST_E) begin : g_msb
         assign shift_next = {shift_reg[WIDTH-2:0], d_q_reg};
      end else begin : g_lsb
         assign shift_next = {d_q_reg, shift_reg[WIDTH-1:1]};
      end
   endgenerate

   assign frame_done = w_rise & (bit_cnt_reg == LAST_BIT);

`ifdef SERIAL_PARITY_EN
   logic parity_ok;
   logic parity_err_reg;

   // The last frame bit is parity: data is already complete in shift_reg.
   assign data_bit  = (bit_cnt_reg != LAST_BIT);
   assign parity_ok = ~(^shift_reg ^ d_q_reg);
   assign push_word = shift_reg;
   assign push      = frame_done & parity_ok;

   // One-cycle flag for a completed frame whose parity did not check out.
   always_ff @(posedge clock_1MHz or posedge rst) begin
      if (rst) begin
         parity_err_reg <= 1'b0;
      end else begin
         parity_err_reg <= frame_done & ~parity_ok;
      end
   end

   assign bus.parity_err_out = parity_err_reg;
`else
   // Every frame bit is data; the final bit completes the word on the fly.
   assign data_bit  = 1'b1;
   assign push_word = shift_next;
   assign push      = frame_done;
`endif

   // Bit counter and shift register advance once per write rise.
   always_ff @(posedge clock_1MHz or posedge rst) begin
      if (rst) begin
         bit_cnt_reg <= '0;
         shift_reg   <= '0;
      end else if (w_rise) begin
         bit_cnt_reg <= (bit_cnt_reg == LAST_BIT) ? '0 : bit_cnt_reg + BW'(1);
         if (data_bit) begin
            shift_reg <= shift_next;
         end
      end
   end

   // Wrap-bit pointer comparison distinguishes full from empty.
   assign empty = (wr_ptr_reg == rd_ptr_reg);
   assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                  (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign count = wr_ptr_reg - rd_ptr_reg;

   // A same-cycle pop frees the slot, so a push into a full FIFO is legal then.
   assign pop   = q_rise & ~empty;
   assign wr_en = push & (~full | pop);

   // Pointer update and sticky overflow on a dropped word.
   always_ff @(posedge clock_1MHz or posedge rst) begin
      if (rst) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
         end
         if (push && full && !pop) begin
            overflow_reg <= 1'b1;
         end
      end
   end

   // Storage write; contents need no reset because empty gates the output.
   always_ff @(posedge clock_1MHz) begin
      if (wr_en) begin
         mem[wr_ptr_reg[AW-1:0]] <= push_word;
      end
   end

   assign bus.status_out   = ~full;
   assign bus.data_out     = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];
   assign bus.count_out    = count;
   assign bus.empty_out    = empty;
   assign bus.overflow_out = overflow_reg;

endmodule

// File: tb/tb_serial_deser_fifo.sv
// Self-checking bench for serial_deser_fifo: an MSB-first and an LSB-first
// instance share one serial stream and are compared with a queue model.
module tb_serial_deser_fifo;

   localparam int DEPTH = 8;
`ifdef SERIAL_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic data_in = 1'b0;
   logic write_in = 1'b0;
   logic dequeue_in = 1'b0;

   int checks = 0;
   int failures = 0;

   logic [7:0] q_m[$];
   logic [7:0] q_l[$];
   bit         ovf_model = 1'b0;

   always #5 clk = ~clk;

   serial_deser_fifo_if #(.WIDTH(8), .DEPTH(DEPTH)) bus_m ();
   serial_deser_fifo_if #(.WIDTH(8), .DEPTH(DEPTH)) bus_l ();

   assign bus_m.data_in    = data_in;
   assign bus_m.write_in   = write_in;
   assign bus_m.dequeue_in = dequeue_in;
   assign bus_l.data_in    = data_in;
   assign bus_l.write_in   = write_in;
   assign bus_l.dequeue_in = dequeue_in;

   serial_deser_fifo #(.WIDTH(8), .DEPTH(DEPTH), .MSB_FIRST(1'b1)) dut_m (
      .clock_1MHz (clk),
      .rst        (rst),
      .bus        (bus_m.slave)
   );

   serial_deser_fifo #(.WIDTH(8), .DEPTH(DEPTH), .MSB_FIRST(1'b0)) dut_l (
      .clock_1MHz (clk),
      .rst        (rst),
      .bus        (bus_l.slave)
   );

`ifdef SERIAL_PARITY_EN
   int perr_m = 0;
   int perr_l = 0;
   always @(posedge clk) begin
      if (bus_m.parity_err_out === 1'b1) perr_m++;
      if (bus_l.parity_err_out === 1'b1) perr_l++;
   end
`endif

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- model ----------------
   function automatic logic [7:0] rev8(input logic [7:0] w);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = w[7-i];
      return r;
   endfunction

   task automatic model_push(input logic [7:0] w);
      if (q_m.size() < DEPTH) begin
         q_m.push_back(w);
         q_l.push_back(rev8(w));
      end else begin
         ovf_model = 1'b1;
      end
   endtask

   task automatic model_pop();
      if (q_m.size() > 0) begin
         void'(q_m.pop_front());
         void'(q_l.pop_front());
      end
   endtask

   task automatic model_clear();
      q_m.delete();
      q_l.delete();
      ovf_model = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b, input int hi, input int lo, input bit with_pop);
      data_in    = b;
      write_in   = 1'b1;
      dequeue_in = with_pop;
      tick(hi);
      write_in   = 1'b0;
      dequeue_in = 1'b0;
      tick(lo);
   endtask

   // Sends w first-bit = w[7]; optional dequeue rise aligned with the final frame bit.
   task automatic send_word(input logic [7:0] w, input int hi, input int lo,
                            input bit pop_last, input bit bad_par);
      for (int i = 0; i < 8; i++)
         send_bit(w[7-i], hi, lo, pop_last && (i == 7) && !PAR);
      if (PAR)
         send_bit((^w) ^ bad_par, hi, lo, pop_last);
      if (pop_last) model_pop();
      if (!(PAR && bad_par)) model_push(w);
   endtask

   task automatic do_pop(input int hi, input int lo);
      dequeue_in = 1'b1;
      tick(hi);
      dequeue_in = 1'b0;
      tick(lo);
      model_pop();
   endtask

   task automatic do_reset();
      write_in   = 1'b0;
      dequeue_in = 1'b0;
      rst        = 1'b1;
      tick(5);
      rst        = 1'b0;
      tick(2);
      model_clear();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      $display("reset: status=%0d empty=%0d count=%0d data=%h ovf=%0d",
               bus_m.status_out, bus_m.empty_out, bus_m.count_out, bus_m.data_out, bus_m.overflow_out);
      checks++;
      if (bus_m.status_out !== 1'b1) begin failures++; $display("FAIL reset_status got %b want 1", bus_m.status_out); end
      checks++;
      if (bus_m.empty_out !== 1'b1) begin failures++; $display("FAIL reset_empty got %b want 1", bus_m.empty_out); end
      checks++;
      if (bus_m.count_out !== 4'd0) begin failures++; $display("FAIL reset_count got %0d want 0", bus_m.count_out); end
      checks++;
      if (bus_m.data_out !== 8'h00) begin failures++; $display("FAIL reset_data got %h want 00", bus_m.data_out); end
      checks++;
      if (bus_m.overflow_out !== 1'b0) begin failures++; $display("FAIL reset_ovf got %b want 0", bus_m.overflow_out); end
      checks++;
      if (bus_l.status_out !== 1'b1 || bus_l.empty_out !== 1'b1) begin
         failures++; $display("FAIL reset_lsb got status=%b empty=%b want 1 1", bus_l.status_out, bus_l.empty_out);
      end
   endtask

   task automatic test_single_word();
      logic [7:0] exp_m;
      logic [7:0] exp_l;
      send_word(8'h80, 10, 10, 1'b0, 1'b0);
      exp_m = q_m[0];
      exp_l = q_l[0];
      $display("single push 80: count=%0d data_m=%h data_l=%h", bus_m.count_out, bus_m.data_out, bus_l.data_out);
      checks++;
      if (bus_m.count_out !== 4'(q_m.size())) begin failures++; $display("FAIL single_count got %0d want %0d", bus_m.count_out, q_m.size()); end
      checks++;
      if (bus_m.data_out !== exp_m) begin failures++; $display("FAIL single_data_msb got %h want %h", bus_m.data_out, exp_m); end
      checks++;
      if (bus_l.data_out !== exp_l) begin failures++; $display("FAIL single_data_lsb got %h want %h", bus_l.data_out, exp_l); end
      checks++;
      if (bus_m.empty_out !== 1'b0) begin failures++; $display("FAIL single_empty got %b want 0", bus_m.empty_out); end
   endtask

   task automatic test_fill_overflow();
      logic [7:0] exp_h;
      do_reset();
      for (int k = 0; k < 9; k++) begin
         send_word(8'h80 + 8'(k), 10, 10, 1'b0, 1'b0);
         exp_h = q_m[0];
         $display("fill push %h: count=%0d status=%0d ovf=%0d", 8'h80 + 8'(k), bus_m.count_out, bus_m.status_out, bus_m.overflow_out);
         checks++;
         if (bus_m.count_out !== 4'(q_m.size())) begin failures++; $display("FAIL fill_count got %0d want %0d", bus_m.count_out, q_m.size()); end
         checks++;
         if (bus_m.status_out !== (q_m.size() < DEPTH)) begin failures++; $display("FAIL fill_status got %b want %b", bus_m.status_out, q_m.size() < DEPTH); end
         checks++;
         if (bus_m.overflow_out !== ovf_model) begin failures++; $display("FAIL fill_ovf got %b want %b", bus_m.overflow_out, ovf_model); end
         checks++;
         if (bus_m.data_out !== exp_h) begin failures++; $display("FAIL fill_head got %h want %h", bus_m.data_out, exp_h); end
      end
      checks++;
      if (bus_l.count_out !== 4'd8 || bus_l.overflow_out !== 1'b1) begin
         failures++; $display("FAIL fill_lsb got count=%0d ovf=%b want 8 1", bus_l.count_out, bus_l.overflow_out);
      end
   endtask

   task automatic test_dequeue();
      logic [7:0] exp_h;
      for (int k = 0; k < 4; k++) begin
         do_pop(200, 600);
         exp_h = (q_m.size() > 0) ? q_m[0] : 8'h00;
         $display("pop: head=%h count=%0d status=%0d ovf=%0d", bus_m.data_out, bus_m.count_out, bus_m.status_out, bus_m.overflow_out);
         checks++;
         if (bus_m.data_out !== exp_h) begin failures++; $display("FAIL deq_head got %h want %h", bus_m.data_out, exp_h); end
         checks++;
         if (bus_m.count_out !== 4'(q_m.size())) begin failures++; $display("FAIL deq_count got %0d want %0d", bus_m.count_out, q_m.size()); end
         checks++;
         if (bus_m.status_out !== 1'b1) begin failures++; $display("FAIL deq_status got %b want 1", bus_m.status_out); end
         checks++;
         if (bus_m.overflow_out !== ovf_model) begin failures++; $display("FAIL deq_ovf got %b want %b", bus_m.overflow_out, ovf_model); end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] w;
      logic [7:0] exp_h;
      do_reset();
      for (int k = 0; k < DEPTH; k++) send_word(8'($urandom), 3, 3, 1'b0, 1'b0);
      w = 8'($urandom);
      send_word(w, 3, 3, 1'b1, 1'b0);
      exp_h = q_m[0];
      $display("push %h with same-cycle pop: count=%0d head=%h ovf=%0d", w, bus_m.count_out, bus_m.data_out, bus_m.overflow_out);
      checks++;
      if (bus_m.count_out !== 4'(q_m.size())) begin failures++; $display("FAIL b2b_count got %0d want %0d", bus_m.count_out, q_m.size()); end
      checks++;
      if (bus_m.overflow_out !== ovf_model) begin failures++; $display("FAIL b2b_ovf got %b want %b", bus_m.overflow_out, ovf_model); end
      checks++;
      if (bus_m.data_out !== exp_h) begin failures++; $display("FAIL b2b_head got %h want %h", bus_m.data_out, exp_h); end
      checks++;
      if (bus_m.status_out !== 1'b0) begin failures++; $display("FAIL b2b_status got %b want 0", bus_m.status_out); end
   endtask

   task automatic test_reset_midword();
      logic [7:0] w;
      for (int i = 0; i < 3; i++) send_bit(1'b1, 3, 3, 1'b0);
      rst = 1'b1;
      #1;
      $display("async reset mid-word: count=%0d status=%0d data=%h", bus_m.count_out, bus_m.status_out, bus_m.data_out);
      checks++;
      if (bus_m.count_out !== 4'd0 || bus_m.empty_out !== 1'b1 || bus_m.status_out !== 1'b1 ||
          bus_m.data_out !== 8'h00 || bus_m.overflow_out !== 1'b0) begin
         failures++;
         $display("FAIL midrst_outputs got count=%0d empty=%b status=%b data=%h ovf=%b want 0 1 1 00 0",
                  bus_m.count_out, bus_m.empty_out, bus_m.status_out, bus_m.data_out, bus_m.overflow_out);
      end
      tick(3);
      rst = 1'b0;
      tick(2);
      model_clear();
      w = 8'($urandom_range(0, 255));
      send_word(w, 3, 3, 1'b0, 1'b0);
      $display("post-reset push %h: data_m=%h data_l=%h count=%0d", w, bus_m.data_out, bus_l.data_out, bus_m.count_out);
      checks++;
      if (bus_m.data_out !== q_m[0]) begin failures++; $display("FAIL midrst_data_msb got %h want %h", bus_m.data_out, q_m[0]); end
      checks++;
      if (bus_l.data_out !== q_l[0]) begin failures++; $display("FAIL midrst_data_lsb got %h want %h", bus_l.data_out, q_l[0]); end
      checks++;
      if (bus_m.count_out !== 4'd1) begin failures++; $display("FAIL midrst_count got %0d want 1", bus_m.count_out); end
   endtask

   task automatic test_random();
      logic [7:0] w;
      logic [7:0] exp_m;
      logic [7:0] exp_l;
      bit         pl;
      do_reset();
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 2) != 0) begin
            w  = 8'($urandom);
            pl = ($urandom_range(0, 3) == 0);
            send_word(w, $urandom_range(2, 4), $urandom_range(2, 4), pl, 1'b0);
            $display("rnd push %h pop=%0d: count=%0d head=%h ovf=%0d", w, pl, bus_m.count_out, bus_m.data_out, bus_m.overflow_out);
         end else begin
            do_pop($urandom_range(2, 4), $urandom_range(2, 4));
            $display("rnd pop: count=%0d head=%h", bus_m.count_out, bus_m.data_out);
         end
         exp_m = (q_m.size() > 0) ? q_m[0] : 8'h00;
         exp_l = (q_l.size() > 0) ? q_l[0] : 8'h00;
         checks++;
         if (bus_m.count_out !== 4'(q_m.size()) || bus_l.count_out !== 4'(q_m.size())) begin
            failures++; $display("FAIL rnd_count got %0d/%0d want %0d", bus_m.count_out, bus_l.count_out, q_m.size());
         end
         checks++;
         if (bus_m.data_out !== exp_m) begin failures++; $display("FAIL rnd_head_msb got %h want %h", bus_m.data_out, exp_m); end
         checks++;
         if (bus_l.data_out !== exp_l) begin failures++; $display("FAIL rnd_head_lsb got %h want %h", bus_l.data_out, exp_l); end
         checks++;
         if (bus_m.status_out !== (q_m.size() < DEPTH) || bus_m.empty_out !== (q_m.size() == 0)) begin
            failures++; $display("FAIL rnd_flags got status=%b empty=%b want %b %b",
                                 bus_m.status_out, bus_m.empty_out, q_m.size() < DEPTH, q_m.size() == 0);
         end
         checks++;
         if (bus_m.overflow_out !== ovf_model || bus_l.overflow_out !== ovf_model) begin
            failures++; $display("FAIL rnd_ovf got %b/%b want %b", bus_m.overflow_out, bus_l.overflow_out, ovf_model);
         end
      end
   endtask

`ifdef SERIAL_PARITY_EN
   task automatic test_parity();
      int pm0;
      int pl0;
      do_reset();
      pm0 = perr_m;
      pl0 = perr_l;
      send_word(8'h81, 4, 4, 1'b0, 1'b0);
      $display("parity good 81: count=%0d data=%h perr=%0d", bus_m.count_out, bus_m.data_out, perr_m - pm0);
      checks++;
      if (bus_m.count_out !== 4'd1 || bus_m.data_out !== 8'h81) begin
         failures++; $display("FAIL par_good got count=%0d data=%h want 1 81", bus_m.count_out, bus_m.data_out);
      end
      checks++;
      if (perr_m != pm0) begin failures++; $display("FAIL par_good_err got %0d pulses want 0", perr_m - pm0); end
      pm0 = perr_m;
      pl0 = perr_l;
      send_word(8'h81, 4, 4, 1'b0, 1'b1);
      $display("parity bad 81: count=%0d perr_m=%0d perr_l=%0d", bus_m.count_out, perr_m - pm0, perr_l - pl0);
      checks++;
      if (bus_m.count_out !== 4'd1 || bus_l.count_out !== 4'd1) begin
         failures++; $display("FAIL par_bad_count got %0d/%0d want 1", bus_m.count_out, bus_l.count_out);
      end
      checks++;
      if (perr_m - pm0 != 1 || perr_l - pl0 != 1) begin
         failures++; $display("FAIL par_bad_pulse got %0d/%0d want 1", perr_m - pm0, perr_l - pl0);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_word();
      test_fill_overflow();
      test_dequeue();
      test_back_to_back();
      test_reset_midword();
      test_random();
`ifdef SERIAL_PARITY_EN
      test_parity();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
